// File: rtl/bram_ctrl_pkg.sv
// Shared state encoding and elaboration helpers for the dual-port BRAM controller.
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        SWEEP = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // Only two BRAM output configurations exist: raw latch output, or output register.
    localparam int RD_LAT_NOREG = 1;
    localparam int RD_LAT_OREG  = 2;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    function automatic bit read_latency_legal(input int lat);
        return (lat == RD_LAT_NOREG) || (lat == RD_LAT_OREG);
    endfunction

endpackage

// File: rtl/bram_dual_port_ctrl_if.sv
// Requester handshakes plus the raw BRAM port pins of the dual-port controller.
interface bram_dual_port_ctrl_if #(
    parameter int RAM_WIDTH = 88,
    parameter int ADDR_W    = 10
);

    logic                 flush_req;
    logic                 flush_busy;
    logic                 flush_done;

    logic                 rd_valid;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_ready;
    logic                 rd_resp_valid;
    logic [RAM_WIDTH-1:0] rd_resp_data;

    logic                 wr_valid;
    logic [ADDR_W-1:0]    wr_addr;
    logic [RAM_WIDTH-1:0] wr_data;
    logic                 wr_ready;

    logic [ADDR_W-1:0]    bram_addra;
    logic [ADDR_W-1:0]    bram_addrb;
    logic [RAM_WIDTH-1:0] bram_dina;
    logic [RAM_WIDTH-1:0] bram_dinb;
    logic                 bram_ena;
    logic                 bram_enb;
    logic                 bram_wea;
    logic                 bram_web;
    logic                 bram_regcea;
    logic                 bram_regceb;
    logic                 bram_rsta;
    logic                 bram_rstb;
    logic [RAM_WIDTH-1:0] bram_douta;
    logic [RAM_WIDTH-1:0] bram_doutb;

    // Controller side.
    modport slave (
        input  flush_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  bram_douta, bram_doutb,
        output flush_busy, flush_done, rd_ready, rd_resp_valid, rd_resp_data, wr_ready,
        output bram_addra, bram_addrb, bram_dina, bram_dinb,
        output bram_ena, bram_enb, bram_wea, bram_web,
        output bram_regcea, bram_regceb, bram_rsta, bram_rstb
    );

    // Requesters and the BRAM itself.
    modport master (
        output flush_req, rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output bram_douta, bram_doutb,
        input  flush_busy, flush_done, rd_ready, rd_resp_valid, rd_resp_data, wr_ready,
        input  bram_addra, bram_addrb, bram_dina, bram_dinb,
        input  bram_ena, bram_enb, bram_wea, bram_web,
        input  bram_regcea, bram_regceb, bram_rsta, bram_rstb
    );

endinterface

// File: rtl/bram_rd_pipe.sv
// Read-valid delay line matching the BRAM read latency; tracks responses still in flight.
module bram_rd_pipe #(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic stage0,
    output logic last,
    output logic empty
);

    logic [READ_LATENCY-1:0] vld_p;

    // empty ignores the last stage: a response leaving this cycle needs no further wait.
    generate
        if (READ_LATENCY == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= '0;
                end else begin
                    vld_p <= accept;
                end
            end
            assign empty = 1'b1;
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= '0;
                end else begin
                    vld_p <= {vld_p[READ_LATENCY-2:0], accept};
                end
            end
            assign empty = ~|vld_p[READ_LATENCY-2:0];
        end
    endgenerate

    assign stage0 = vld_p[0];
    assign last   = vld_p[READ_LATENCY-1];

endmodule

// File: rtl/bram_dual_port_ctrl.sv
// Front end of a single-clock true dual-port BRAM: port A serves reads, port B serves
// writes, and both ports together zero the array after reset or a flush.
module bram_dual_port_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH    = 88,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1
) (
    input logic                  clka,
    input logic                  rsta_n,
    bram_dual_port_ctrl_if.slave bus
);

    localparam int              ADDR_W    = clog2(RAM_DEPTH);
    localparam int              LAST_CNT  = RAM_DEPTH - 2;
    localparam logic [ADDR_W:0] DEPTH_EXT = RAM_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_EXT  = LAST_CNT[ADDR_W:0];

    generate
        if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
            $error("bram_dual_port_ctrl: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    ctrl_state_t          state;
    ctrl_state_t          state_nxt;
    logic [ADDR_W-1:0]    cnt;
    logic [ADDR_W-1:0]    cnt_nxt;
    logic [ADDR_W:0]      cnt_ext;
    logic [ADDR_W:0]      cnt_p1;
    logic                 flush_done_q;
    logic                 flush_done_nxt;

    logic                 in_run;
    logic                 rd_ready;
    logic                 wr_ready;
    logic                 rd_fire;
    logic                 wr_fire;
    logic                 rd_stage0;
    logic                 rd_last;
    logic                 rd_empty;

    logic                 ena;
    logic                 enb;
    logic                 wea;
    logic                 web;
    logic [ADDR_W-1:0]    addra;
    logic [ADDR_W-1:0]    addrb;
    logic [RAM_WIDTH-1:0] dina;
    logic [RAM_WIDTH-1:0] dinb;
    logic                 unused_doutb;

    assign cnt_ext = {1'b0, cnt};
    assign cnt_p1  = cnt_ext + (ADDR_W+1)'(1);

    // Same-address write stalls the read: the primitive is collision-unsafe across ports.
    assign in_run   = (state == RUN);
    assign wr_ready = in_run;
    assign rd_ready = in_run && !(bus.wr_valid && (bus.wr_addr == bus.rd_addr));
    assign rd_fire  = bus.rd_valid && rd_ready;
    assign wr_fire  = bus.wr_valid && wr_ready;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state        <= SWEEP;
            cnt          <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            flush_done_q <= flush_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        flush_done_nxt = 1'b0;
        ena            = 1'b0;
        wea            = 1'b0;
        addra          = bus.rd_addr;
        dina           = '0;
        enb            = 1'b0;
        web            = 1'b0;
        addrb          = bus.wr_addr;
        dinb           = bus.wr_data;

        case (state)
            SWEEP: begin
                ena   = 1'b1;
                wea   = 1'b1;
                addra = cnt;
                enb   = (cnt_p1 < DEPTH_EXT);
                web   = (cnt_p1 < DEPTH_EXT);
                addrb = cnt_p1[ADDR_W-1:0];
                dinb  = '0;
                if (cnt_ext >= LAST_EXT) begin
                    state_nxt      = RUN;
                    cnt_nxt        = '0;
                    flush_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(2);
                end
            end
            RUN: begin
                ena = rd_fire;
                enb = wr_fire;
                web = wr_fire;
                if (bus.flush_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_empty) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SWEEP;
                cnt_nxt   = '0;
            end
        endcase
    end

    bram_rd_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk    (clka),
        .rst_n  (rsta_n),
        .accept (rd_fire),
        .stage0 (rd_stage0),
        .last   (rd_last),
        .empty  (rd_empty)
    );

    assign bus.flush_busy    = (state != RUN);
    assign bus.flush_done    = flush_done_q;
    assign bus.rd_ready      = rd_ready;
    assign bus.wr_ready      = wr_ready;
    assign bus.rd_resp_valid = rd_last;
    assign bus.rd_resp_data  = bus.bram_douta;

    assign bus.bram_ena    = ena;
    assign bus.bram_wea    = wea;
    assign bus.bram_addra  = addra;
    assign bus.bram_dina   = dina;
    assign bus.bram_enb    = enb;
    assign bus.bram_web    = web;
    assign bus.bram_addrb  = addrb;
    assign bus.bram_dinb   = dinb;
    assign bus.bram_regcea = (READ_LATENCY == RD_LAT_OREG) ? rd_stage0 : 1'b0;
    assign bus.bram_regceb = 1'b0;
    assign bus.bram_rsta   = 1'b0;
    assign bus.bram_rstb   = 1'b0;

    assign unused_doutb = ^bus.bram_doutb;

endmodule

// File: doc/bram_dual_port_ctrl.md
Name: bram_dual_port_ctrl

Overview:
- Controller sitting in front of a true dual-port, read-first, single-clock BRAM used for cache tag/data storage.
- Statically shares the two BRAM ports between one read requester (port A) and one write requester (port B).
- Stalls reads that collide with a same-cycle, same-address write.
- Clears the whole array after reset and on a flush command, sweeping two entries per cycle with both ports.

Parameters:
- RAM_WIDTH, 88, data width of each BRAM entry.
- RAM_DEPTH, 1024, number of entries; ADDR_W = clog2(RAM_DEPTH).
- READ_LATENCY, 1, BRAM read latency in cycles: 1 = no output register, 2 = output register; no other values are legal.

Ports:
- clka  in  1  clock
- rsta_n  in  1  asynchronous active-low reset
- flush_req  in  1  level request to clear the array
- flush_busy  out  1  high in DRAIN and SWEEP
- flush_done  out  1  one-cycle pulse when a sweep completes
- rd_valid  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_ready  out  1  read accepted when rd_valid && rd_ready
- rd_resp_valid  out  1  read data valid
- rd_resp_data  out  RAM_WIDTH  read data
- wr_valid  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  RAM_WIDTH  write data
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- bram_addra, bram_addrb  out  ADDR_W  BRAM addresses
- bram_dina, bram_dinb  out  RAM_WIDTH  BRAM write data
- bram_ena, bram_enb, bram_wea, bram_web  out  1  BRAM enables and write enables
- bram_regcea, bram_regceb  out  1  BRAM output register enables
- bram_rsta, bram_rstb  out  1  BRAM output resets, tied 0
- bram_douta  in  RAM_WIDTH  BRAM port A data
- bram_doutb  in  RAM_WIDTH  BRAM port B data, unused

Behaviour:
- States: SWEEP, RUN, DRAIN. Registers: state, sweep counter cnt (ADDR_W bits), read-valid delay line (READ_LATENCY bits), flush_done.
- Reset (rsta_n=0), asynchronous:
  - state=SWEEP, cnt=0, delay line=0, flush_done=0.
  - Hence rd_ready=0, wr_ready=0, rd_resp_valid=0, flush_busy=1.
  - BRAM outputs follow the SWEEP decode; zero writes to addresses 0/1 during reset are permitted.
  - A reset arriving mid-sweep restarts the sweep from 0. A reset arriving mid-read discards the pending response.
- SWEEP:
  - bram_ena=bram_wea=1, addra=cnt, dina=0.
  - bram_enb=bram_web=(cnt+1<RAM_DEPTH), addrb=cnt+1, dinb=0.
  - cnt+=2 per cycle.
  - Last cycle is cnt>=RAM_DEPTH-2. Next state RUN, cnt<=0, flush_done<=1 for exactly one cycle.
  - Sweep length is ceil(RAM_DEPTH/2) cycles. RAM_DEPTH=1024 gives 512 cycles.
- RUN:
  - wr_ready=1. On a write handshake: enb=web=1, addrb=wr_addr, dinb=wr_data. The write lands at that edge; no response.
  - rd_ready = !(wr_valid && wr_addr==rd_addr). On a read handshake: ena=1, wea=0, addra=rd_addr.
  - The collision stall applies even though the BRAM is read-first, because it is multi-port collision-unsafe in hardware. The read is accepted the next cycle and returns the new data.
  - flush_req=1 in RUN moves to DRAIN next cycle. Handshakes in that same cycle are still honoured.
- DRAIN:
  - rd_ready=wr_ready=0, no BRAM enables.
  - Stay until the delay line is empty, then go to SWEEP with cnt=0.
  - With READ_LATENCY=1 and a read accepted on the flush cycle, DRAIN lasts 1 cycle.
- flush_req is sampled only in RUN. If held high, another flush starts after the first RUN cycle.
- Read pipeline:
  - Delay line stage 0 is set by the read handshake.
  - rd_resp_valid = last stage, exactly READ_LATENCY cycles after acceptance. rd_resp_data = bram_douta, passed through unregistered.
  - bram_regcea = stage 0 when READ_LATENCY=2, otherwise 0. bram_regceb=0.
  - Back-to-back reads are supported at 1 per cycle.
- Registered outputs: flush_done. All other outputs decode combinationally from registers and inputs. Ready signals never depend on the other requester's ready.

Decomposition:
- Package bram_ctrl_pkg holds:
  - State encoding: SWEEP=2'd0, RUN=2'd1, DRAIN=2'd2.
  - The clog2 function.
  - Legal READ_LATENCY values.
- Sub-module bram_rd_pipe: parameterised READ_LATENCY valid shift register with async active-low reset. It exposes stage 0 (for regce), last-stage valid, and an empty flag.

Test Plan (RAM_DEPTH=16, RAM_WIDTH=8 unless noted):
- Release reset -> flush_busy=1 for 8 cycles, addra 0,2,…,14 and addrb 1,…,15 written 0. flush_done pulses once, then wr_ready=1.
- RUN, write addr 5=0xA5, then read addr 5 next cycle -> rd_resp_valid after READ_LATENCY cycles with 0xA5. Repeat with READ_LATENCY=2 and check bram_regcea timing.
- Same cycle wr_valid addr 3=0x3C and rd_valid addr 3 -> rd_ready=0 that cycle. Read accepted next cycle and returns 0x3C. A different-address pair is accepted in the same cycle.
- Read accepted in the same cycle flush_req rises -> response still returned, one DRAIN cycle, sweep of 8 cycles, then read of addr 5 returns 0.
- RAM_DEPTH=15 -> 8 sweep cycles, bram_enb=0 on the final cycle (cnt=14), all 15 entries zero.
- rsta_n pulsed low at sweep cycle 4 -> outputs reset immediately, sweep restarts at cnt=0 and runs a full 8 cycles.
